// File: rtl/pad_frame_writer_if.sv
// Pixel-stream and SRAM write-port bundle for pad_frame_writer.
// The slave modport is the writer itself; the master modport is whatever drives it.
interface pad_frame_writer_if;
    logic        i_start;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_r;
    logic [7:0]  i_g;
    logic [7:0]  i_b;
    logic        i_stall;
    logic [19:0] o_sram_addr;
    logic [15:0] o_sram_wdata;
    logic        o_sram_we;
    logic        o_busy;
    logic        o_finish;

    modport slave (
        input  i_start, i_valid, i_r, i_g, i_b, i_stall,
        output o_ready, o_sram_addr, o_sram_wdata, o_sram_we, o_busy, o_finish
    );

    modport master (
        output i_start, i_valid, i_r, i_g, i_b, i_stall,
        input  o_ready, o_sram_addr, o_sram_wdata, o_sram_we, o_busy, o_finish
    );
endinterface

// File: rtl/pad_frame_writer.sv
// Writes a raster RGB stream into SRAM as a zero-padded single-channel frame.
// Define PAD_FRAME_WRITER_LUMA_EN to store luma instead of min(r,g,b).
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | waiting for i_start, address parked at BASE_ADDR
// TOP_PAD   | first PAD_L rows, every column written with PAD_VAL
// LEFT_PAD  | first PAD_L columns of an image row
// DATA      | IMG_W pixel columns, one write per handshake
// RIGHT_PAD | last PAD_R columns of an image row
// BOT_PAD   | last PAD_R rows, every column written with PAD_VAL
// DONE      | one-cycle o_finish, then back to IDLE
module pad_frame_writer #(
    parameter int unsigned BASE_ADDR = 500000,
    parameter int unsigned IMG_W     = 320,
    parameter int unsigned IMG_H     = 480,
    parameter int unsigned PAD_L     = 64,
    parameter int unsigned PAD_R     = 63,
    parameter logic [7:0]  PAD_VAL   = 8'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    pad_frame_writer_if.slave  bus
);
    localparam int unsigned W_TOT = PAD_L + IMG_W + PAD_R;
    localparam int unsigned H_TOT = PAD_L + IMG_H + PAD_R;
    localparam int CW = (W_TOT > 1) ? $clog2(W_TOT) : 1;
    localparam int RW = (H_TOT > 1) ? $clog2(H_TOT + 1) : 1;

    localparam logic [CW-1:0] C_LAST     = CW'(W_TOT - 1);
    localparam logic [CW-1:0] C_LPAD_END = CW'(PAD_L - 1);
    localparam logic [CW-1:0] C_DATA_END = CW'(PAD_L + IMG_W - 1);
    localparam logic [RW-1:0] R_TOP_END  = RW'(PAD_L - 1);
    localparam logic [RW-1:0] R_IMG_END  = RW'(PAD_L + IMG_H - 1);
    localparam logic [RW-1:0] R_LAST     = RW'(H_TOT - 1);
    localparam logic [19:0]   A_BASE     = 20'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE, S_TOP_PAD, S_LEFT_PAD, S_DATA, S_RIGHT_PAD, S_BOT_PAD, S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [19:0]   r_addr;
    logic          w_we;
    logic          w_ready;
    logic          w_finish;
    logic [15:0]   w_wdata;
    logic [7:0]    w_value;

`ifdef PAD_FRAME_WRITER_LUMA_EN
    logic [15:0] w_luma;
    // Max sum is 256*255, so 16 bits never overflow.
    assign w_luma  = 16'd77  * {8'd0, bus.i_r}
                   + 16'd150 * {8'd0, bus.i_g}
                   + 16'd29  * {8'd0, bus.i_b};
    assign w_value = 8'(w_luma >> 8);
`else
    logic [7:0] w_min_rg;
    assign w_min_rg = (bus.i_r < bus.i_g) ? bus.i_r : bus.i_g;
    assign w_value  = (w_min_rg < bus.i_b) ? w_min_rg : bus.i_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (bus.i_start && !bus.i_stall) w_next = S_TOP_PAD;
            S_TOP_PAD:   if (w_we && r_row == R_TOP_END && r_col == C_LAST) w_next = S_LEFT_PAD;
            S_LEFT_PAD:  if (w_we && r_col == C_LPAD_END) w_next = S_DATA;
            S_DATA:      if (w_we && r_col == C_DATA_END) w_next = S_RIGHT_PAD;
            S_RIGHT_PAD: if (w_we && r_col == C_LAST)
                             w_next = (r_row == R_IMG_END) ? S_BOT_PAD : S_LEFT_PAD;
            S_BOT_PAD:   if (w_we && r_row == R_LAST && r_col == C_LAST) w_next = S_DONE;
            S_DONE:      if (!bus.i_stall) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Write strobe and data are combinational so a handshake lands in SRAM the same cycle.
    always_comb begin
        w_we     = 1'b0;
        w_ready  = 1'b0;
        w_finish = 1'b0;
        w_wdata  = 16'd0;
        case (r_state)
            S_TOP_PAD, S_LEFT_PAD, S_RIGHT_PAD, S_BOT_PAD: begin
                w_we    = !bus.i_stall;
                w_wdata = {8'd0, PAD_VAL};
            end
            S_DATA: begin
                w_ready = !bus.i_stall;
                w_we    = bus.i_valid && !bus.i_stall;
                w_wdata = {8'd0, w_value};
            end
            S_DONE:  w_finish = !bus.i_stall;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= A_BASE;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_we) begin
            r_addr <= r_addr + 20'd1;
            if (r_col == C_LAST) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end else if (r_state == S_DONE && !bus.i_stall) begin
            r_addr <= A_BASE;
            r_row  <= '0;
            r_col  <= '0;
        end
    end

    assign bus.o_sram_addr  = r_addr;
    assign bus.o_sram_wdata = w_wdata;
    assign bus.o_sram_we    = w_we;
    assign bus.o_ready      = w_ready;
    assign bus.o_busy       = (r_state != S_IDLE);
    assign bus.o_finish     = w_finish;
endmodule

// File: tb/tb_pad_frame_writer.sv
// Self-checking bench for pad_frame_writer on a reduced frame geometry.
// Pixel expectations come from a hand-computed vector table; placement from a position model.
`timescale 1ns/1ps
module tb_pad_frame_writer;
    localparam int unsigned BASE  = 500000;
    localparam int unsigned IW    = 4;
    localparam int unsigned IH    = 3;
    localparam int unsigned PL    = 2;
    localparam int unsigned PR    = 1;
    localparam logic [7:0]  PV    = 8'h00;
    localparam int unsigned WT    = PL + IW + PR;
    localparam int unsigned HT    = PL + IH + PR;
    localparam int unsigned TOTAL = WT * HT;
    localparam int unsigned NPIX  = IW * IH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pad_frame_writer_if bus();

    pad_frame_writer #(
        .BASE_ADDR(BASE), .IMG_W(IW), .IMG_H(IH),
        .PAD_L(PL), .PAD_R(PR), .PAD_VAL(PV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] e_min;
        logic [7:0] e_luma;
    } pix_t;

    pix_t vec [NPIX];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic bit is_data(input int unsigned k);
        int unsigned row, col;
        row = k / WT;
        col = k % WT;
        return (row >= PL) && (row < PL + IH) && (col >= PL) && (col < PL + IW);
    endfunction

    function automatic logic [7:0] exp_val(input int unsigned i);
`ifdef PAD_FRAME_WRITER_LUMA_EN
        return vec[i].e_luma;
`else
        return vec[i].e_min;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_we"},     {31'd0, bus.o_sram_we}, 32'd0);
        check({tag, "_busy"},   {31'd0, bus.o_busy},    32'd0);
        check({tag, "_ready"},  {31'd0, bus.o_ready},   32'd0);
        check({tag, "_finish"}, {31'd0, bus.o_finish},  32'd0);
        check({tag, "_addr"},   {12'd0, bus.o_sram_addr}, BASE);
    endtask

    // One frame: optional stalls (TOP_PAD + DATA), a 5-cycle valid gap, or a start-while-busy
    // pulse followed by a reset in the middle of DATA.
    task automatic run_frame(input bit do_stall, input bit do_gap, input bit do_abort);
        int unsigned k, di, nw;
        int stall_left, gap_left;
        bit st1, st2, gapd, startd, seen_ready, fin;
        bit data_pos, exp_we, exp_rdy;
        k = 0; di = 0; nw = 0; stall_left = 0; gap_left = 0;
        st1 = 0; st2 = 0; gapd = 0; startd = 0; seen_ready = 0; fin = 0;
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_valid = 1'b1; bus.i_stall = 1'b0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            if (do_stall && stall_left == 0 && !st1 && k == 3) begin stall_left = 3; st1 = 1; end
            if (do_stall && stall_left == 0 && !st2 && di == 5 && is_data(k)) begin stall_left = 3; st2 = 1; end
            if (do_gap && gap_left == 0 && !gapd && di == 2 && is_data(k)) begin gap_left = 5; gapd = 1; end
            bus.i_stall = (stall_left > 0);
            bus.i_valid = (gap_left == 0);
            bus.i_start = 1'b0;
            if (do_abort && k == 4 && !startd) begin bus.i_start = 1'b1; startd = 1; end
            bus.i_r = vec[(di < NPIX) ? di : 0].r;
            bus.i_g = vec[(di < NPIX) ? di : 0].g;
            bus.i_b = vec[(di < NPIX) ? di : 0].b;
            if (do_abort && di == 1 && is_data(k)) begin
                rst_n = 1'b0;
                @(negedge clk);
                check_idle("abort_rst");
                @(posedge clk); #1;
                rst_n = 1'b1;
                bus.i_valid = 1'b1;
                @(negedge clk);
                check_idle("abort_post");
                return;
            end
            @(negedge clk);
            data_pos = (k < TOTAL) && is_data(k);
            exp_we   = (k < TOTAL) && !bus.i_stall && (!data_pos || bus.i_valid);
            exp_rdy  = data_pos && !bus.i_stall;
            check("busy",   {31'd0, bus.o_busy},      32'd1);
            check("we",     {31'd0, bus.o_sram_we},   {31'd0, exp_we});
            check("ready",  {31'd0, bus.o_ready},     {31'd0, exp_rdy});
            check("finish", {31'd0, bus.o_finish},    {31'd0, (k == TOTAL)});
            if (k < TOTAL) check("addr", {12'd0, bus.o_sram_addr}, BASE + k);
            if (exp_rdy && !seen_ready) begin
                seen_ready = 1;
                check("first_ready_addr", {12'd0, bus.o_sram_addr}, BASE + PL*WT + PL);
            end
            if (bus.o_sram_we) begin
                if (data_pos) check("pix_wdata", {16'd0, bus.o_sram_wdata}, {24'd0, exp_val(di)});
                else          check("pad_wdata", {16'd0, bus.o_sram_wdata}, {24'd0, PV});
                if (k == 0) check("first_addr", {12'd0, bus.o_sram_addr}, BASE);
                if (data_pos && di == IW - 1)
                    check("row0_last_pix_addr", {12'd0, bus.o_sram_addr}, BASE + PL*WT + PL + IW - 1);
                if (data_pos && di == NPIX - 1)
                    check("last_pix_addr", {12'd0, bus.o_sram_addr}, BASE + (PL+IH-1)*WT + PL + IW - 1);
                if (k == TOTAL - 1) check("last_addr", {12'd0, bus.o_sram_addr}, BASE + TOTAL - 1);
                nw++;
                k++;
                if (data_pos) di++;
            end
            if (bus.o_finish) fin = 1;
            if (stall_left > 0) stall_left--;
            if (gap_left > 0) gap_left--;
            @(posedge clk); #1;
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: no o_finish after %0d writes, expected %0d", nw, TOTAL);
        end
        check("write_count", nw, TOTAL);
        bus.i_valid = 1'b1;
        @(negedge clk);
        check_idle("post_frame");
    endtask

    initial begin
        vec[0]  = '{8'd200, 8'd90,  8'd150, 8'h5A, 8'h81};
        vec[1]  = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
        vec[2]  = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        vec[3]  = '{8'd10,  8'd10,  8'd10,  8'd10,  8'd10};
        vec[4]  = '{8'd100, 8'd50,  8'd50,  8'd50,  8'd65};
        vec[5]  = '{8'd1,   8'd2,   8'd3,   8'd1,   8'd1};
        vec[6]  = '{8'd255, 8'd0,   8'd0,   8'd0,   8'd76};
        vec[7]  = '{8'd0,   8'd255, 8'd0,   8'd0,   8'd149};
        vec[8]  = '{8'd0,   8'd0,   8'd255, 8'd0,   8'd28};
        vec[9]  = '{8'd30,  8'd20,  8'd40,  8'd20,  8'd25};
        vec[10] = '{8'd128, 8'd64,  8'd32,  8'd32,  8'd79};
        vec[11] = '{8'd7,   8'd200, 8'd7,   8'd7,   8'd120};

        bus.i_start = 1'b0; bus.i_valid = 1'b0; bus.i_stall = 1'b0;
        bus.i_r = 8'd0; bus.i_g = 8'd0; bus.i_b = 8'd0;
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check("reset_wdata", {16'd0, bus.o_sram_wdata}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Valid pixels while IDLE must not be taken or written.
        bus.i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("idle_valid");
        end

        run_frame(1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b1, 1'b0);
        run_frame(1'b0, 1'b0, 1'b1);
        run_frame(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
